multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Multicycle control FSM for the RV32I core: sequences the shared ALU, register file and unified
//   instruction/data memory over FETCH/DECODE/EXECUTE/MEM/WB steps, replacing single-cycle decode.
// - Sits beside the multicycle datapath; takes opcode fields, Zero and a memory ready handshake,
//   drives every datapath select/enable. Unsupported opcodes and memory timeouts halt the core.
// PARAMETERS
// - TIMEOUT_CYCLES  default 0  max cycles waiting on MemReady before TRAP; 0 = never time out
// - TO_W            default 8  width of the wait counter; TIMEOUT_CYCLES must be < 2**TO_W
// PORTS
// - clk         in   1  rising-edge clock
// - reset       in   1  asynchronous, active-low reset (0 = reset asserted)
// - op          in   7  Instr[6:0] from instruction register
// - funct3      in   3  Instr[14:12]
// - funct7b5    in   1  Instr[30]
// - Zero        in   1  ALU zero flag
// - MemReady    in   1  memory completes current read/write this cycle
// - PCWrite     out  1  PC register enable
// - AdrSrc      out  1  memory address: 0 = PC, 1 = ALUOut
// - MemRead     out  1  memory read request
// - MemWrite    out  1  memory write request
// - IRWrite     out  1  instruction register (and OldPC) enable
// - ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
// - ALUSrcA     out  2  00 PC, 01 OldPC, 10 rs1 reg
// - ALUSrcB     out  2  00 rs2 reg, 01 ImmExt, 10 const 4
// - ImmSrc      out  2  00 I, 01 S, 10 B, 11 J
// - ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
// - RegWrite    out  1  register-file write enable
// - Halted      out  1  sticky: core in TRAP
// - State       out  4  current state code (debug)
// BEHAVIOUR
// - Outputs are Moore from State, except as noted; all unlisted outputs are 0 in a state.
// - PCWrite = PCUpdate | (Branch & Zero).
// - ImmSrc is decoded from op in every state: lw/addi 00, sw 01, beq 10, jal 11, other 00.
// - Reset: State = FETCH (0), wait counter = 0, Halted = 0; outputs immediately take FETCH values.
//   Reset asserted mid-MEMWRITE drops MemWrite combinationally.
// - FETCH(0): AdrSrc 0, MemRead 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
//   - IRWrite = PCUpdate = MemReady (Mealy). MemReady -> DECODE, else stay.
// - DECODE(1): ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target to ALUOut).
//   - 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL;
//     1100011 -> BEQ; any other op -> TRAP.
// - MEMADR(2): ALUSrcA 10, ALUSrcB 01, ALUOp 00; op[5]=0 -> MEMREAD, else MEMWRITE.
// - MEMREAD(3): AdrSrc 1, MemRead 1, ResultSrc 00; MemReady -> MEMWB, else stay.
// - MEMWB(4): ResultSrc 01, RegWrite 1 -> FETCH.
// - MEMWRITE(5): AdrSrc 1, MemWrite 1, ResultSrc 00; MemReady -> FETCH, else stay.
// - EXECR(6): ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB.
// - ALUWB(7): ResultSrc 00, RegWrite 1 -> FETCH.
// - EXECI(8): ALUSrcA 10, ALUSrcB 01, ALUOp 10 -> ALUWB.
// - JAL(9): ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB.
// - BEQ(10): ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1 -> FETCH.
// - TRAP(11): Halted 1, all enables 0; leaves only on reset.
// - Codes 12-15 are unreachable; if entered -> TRAP.
// - Wait counter counts cycles spent in FETCH/MEMREAD/MEMWRITE with MemReady=0.
//   - Clears on any state change.
//   - If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with MemReady still 0 -> TRAP.
//   - MemReady in that same cycle wins.
// - ALU decode:
//   - ALUOp 00 -> add; 01 -> sub.
//   - ALUOp 10 by funct3: 000 -> sub if op[5]&funct7b5 else add; 010 slt; 110 or; 111 and;
//     other funct3 -> add.
// - Latency with MemReady tied 1: R/I-type 4, lw 5, sw 4, beq 3, jal 4 cycles.
// STRUCTURE
// - riscv_ctrl_pkg: state codes, opcode constants, ALUControl/ResultSrc/ALUSrc encodings.
// - One sub-module: alu_decoder (op[5], funct3, funct7b5, ALUOp -> ALUControl), combinational.
// - Top: state register, next-state logic, output decode, wait counter.
// TESTING
// - Hold reset=0 for 3 cycles then release -> State=0, MemRead=1, IRWrite=0, Halted=0 throughout.
// - add (op 0110011, funct3 000, funct7b5 0) with MemReady=1 -> states 0,1,6,7;
//   ALUControl=000 in EXECR; RegWrite=1 only in ALUWB.
// - lw, MemReady low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4;
//   AdrSrc=1 during 3; RegWrite=1 with ResultSrc=01 in 4.
// - beq, Zero=1 -> PCWrite=1 in BEQ; repeat with Zero=0 -> PCWrite=0; both return to FETCH.
// - TIMEOUT_CYCLES=4, MemReady stuck 0 in FETCH -> TRAP after 4 wait cycles; Halted=1 until reset.
// - op 1110011 -> DECODE then TRAP.
// - Reset pulsed during MEMWRITE -> MemWrite=0 immediately and State=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: state codes, opcodes,
// datapath select values and the per-state Moore control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic       halted;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:  c.reg_write = 1'b1;
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_TRAP:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src(logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select from ALUOp and the instruction function fields.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback,
// halts on unsupported opcodes or memory handshake timeout.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 on MemReady
// DECODE   | branch target to ALUOut, dispatch on opcode
// MEMADR   | compute load/store address
// MEMREAD  | load data from memory
// MEMWB    | write loaded data to register file
// MEMWRITE | store to memory
// EXECR    | R-type ALU operation
// ALUWB    | write ALU result to register file
// EXECI    | I-type ALU operation
// JAL      | jump: link value and PC update
// BEQ      | compare, branch on Zero
// TRAP     | halted until reset
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Halted,
    output logic [3:0] State
);

    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state;
    state_t          state_n;
    ctrl_t           ctrl;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting;
    logic            timeout;

    assign waiting = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !MemReady;
    // The cycle that would bring the count to TIMEOUT_CYCLES is the one that traps.
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (wait_cnt == TO_LAST);

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:    if (MemReady) state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_JAL:       state_n = S_JAL;
                    OP_BEQ:       state_n = S_BEQ;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR:   state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_n = S_MEMWB;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: if (MemReady) state_n = S_FETCH;
            S_EXECR:    state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_EXECI:    state_n = S_ALUWB;
            S_JAL:      state_n = S_ALUWB;
            S_BEQ:      state_n = S_FETCH;
            S_TRAP:     state_n = S_TRAP;
            default:    state_n = S_TRAP;
        endcase
        if (timeout) state_n = S_TRAP;
    end

    // Control word is registered alongside the state so Moore outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            ctrl     <= state_ctrl(S_FETCH);
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            ctrl  <= state_ctrl(state_n);
            if (state_n != state)
                wait_cnt <= '0;
            else if (waiting && wait_cnt != '1)
                wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    alu_decoder u_alu_decoder (
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (ctrl.alu_op),
        .alu_control (ALUControl)
    );

    assign IRWrite   = ctrl.fetch & MemReady;
    assign PCWrite   = (ctrl.fetch & MemReady) | ctrl.pc_update | (ctrl.branch & Zero);
    assign AdrSrc    = ctrl.adr_src;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ImmSrc    = imm_src(op);
    assign RegWrite  = ctrl.reg_write;
    assign Halted    = ctrl.halted;
    assign State     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written trap/reset
// sequences, and randomized instruction streams against a phase-list model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [21:0] act_vec;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .Halted(Halted), .State(State)
    );

    assign act_vec = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ImmSrc, ALUControl, RegWrite, Halted, State};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instruction is a list of step numbers; memory steps repeat while MemReady=0.
    int seq[$];
    int wcnt;
    bit need_instr;

    task automatic model_reset();
        seq.delete();
        wcnt = 0;
        need_instr = 1'b1;
    endtask

    task automatic start_instr(logic [6:0] o, logic [2:0] f3, logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        seq.delete();
        seq.push_back(0);
        seq.push_back(1);
        case (o)
            7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            7'b0100011: begin seq.push_back(2); seq.push_back(5); end
            7'b0110011: begin seq.push_back(6); seq.push_back(7); end
            7'b0010011: begin seq.push_back(8); seq.push_back(7); end
            7'b1101111: begin seq.push_back(9); seq.push_back(7); end
            7'b1100011: seq.push_back(10);
            default:    seq.push_back(11);
        endcase
        need_instr = 1'b0;
    endtask

    function automatic int cur_phase();
        return need_instr ? 0 : seq[0];
    endfunction

    task automatic model_advance(bit mr);
        int p;
        p = cur_phase();
        if (p == 11) return;
        if ((p == 0 || p == 3 || p == 5) && !mr) begin
            wcnt++;
            if (TO != 0 && wcnt >= TO) begin
                seq.delete();
                seq.push_back(11);
                need_instr = 1'b0;
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
            void'(seq.pop_front());
            if (seq.size() == 0) need_instr = 1'b1;
        end
    endtask

    function automatic logic [2:0] funct_alu();
        case (funct3)
            3'b000:  return (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [21:0] expect_outs(int p, bit mr);
        logic       pcw, adr, mrd, mwr, irw, rw, hlt;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        {pcw, adr, mrd, mwr, irw, rw, hlt} = '0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        case (op)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
            7'b1101111: imm = 2'b11;
            default:    imm = 2'b00;
        endcase
        case (p)
            0:  begin mrd = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin adr = 1; mrd = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mwr = 1; end
            6:  begin sa = 2'b10; sb = 2'b00; alu = funct_alu(); end
            7:  rw = 1;
            8:  begin sa = 2'b10; sb = 2'b01; alu = funct_alu(); end
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            10: begin sa = 2'b10; alu = 3'b001; pcw = Zero; end
            default: hlt = 1;
        endcase
        return {pcw, adr, mrd, mwr, irw, rs, sa, sb, imm, alu, rw, hlt, 4'(p)};
    endfunction

    // Called just after a rising edge; checks at the falling edge, advances model at the next rise.
    task automatic step(bit mr, int exp_state, string tag);
        MemReady = mr;
        @(negedge clk);
        cmp({tag, " outs"}, 32'(act_vec), 32'(expect_outs(cur_phase(), mr)));
        if (exp_state >= 0) cmp({tag, " state"}, 32'(State), exp_state);
        @(posedge clk);
        model_advance(mr);
        #1;
    endtask

    task automatic apply_reset(int ncyc, bit mr);
        reset = 1'b0;
        MemReady = mr;
        model_reset();
        repeat (ncyc) begin
            @(negedge clk);
            cmp("reset outs", 32'(act_vec), 32'(expect_outs(0, mr)));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         stall_at;
        int         stall_n;
        int         n;
        logic [31:0] st;   // nibble i = expected state in cycle i
    } vec_t;

    function automatic vec_t mk(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                                int sat, int sn, int n, logic [31:0] st);
        vec_t v;
        v.name = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z;
        v.stall_at = sat; v.stall_n = sn; v.n = n; v.st = st;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int trap_cycles;
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
        model_reset();

        vecs.push_back(mk("add",   7'b0110011, 3'b000, 1'b0, 1'b0, -1, 0, 4, 32'h7610));
        vecs.push_back(mk("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, -1, 0, 4, 32'h7610));
        vecs.push_back(mk("slt",   7'b0110011, 3'b010, 1'b0, 1'b0, -1, 0, 4, 32'h7610));
        vecs.push_back(mk("or",    7'b0110011, 3'b110, 1'b0, 1'b0, -1, 0, 4, 32'h7610));
        vecs.push_back(mk("and",   7'b0110011, 3'b111, 1'b0, 1'b0, -1, 0, 4, 32'h7610));
        vecs.push_back(mk("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, -1, 0, 4, 32'h7810));
        vecs.push_back(mk("lw",    7'b0000011, 3'b010, 1'b0, 1'b0,  3, 2, 7, 32'h4333210));
        vecs.push_back(mk("sw",    7'b0100011, 3'b010, 1'b0, 1'b0,  3, 1, 5, 32'h55210));
        vecs.push_back(mk("beq1",  7'b1100011, 3'b000, 1'b0, 1'b1, -1, 0, 3, 32'hA10));
        vecs.push_back(mk("beq0",  7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0, 3, 32'hA10));
        vecs.push_back(mk("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, -1, 0, 4, 32'h7910));
        vecs.push_back(mk("fstall",7'b0110011, 3'b000, 1'b0, 1'b0,  0, 3, 7, 32'h7610000));

        // Reset held three cycles with memory idle.
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmp("rst State", 32'(State), 0);
            cmp("rst MemRead", 32'(MemRead), 1);
            cmp("rst IRWrite", 32'(IRWrite), 0);
            cmp("rst Halted", 32'(Halted), 0);
            @(posedge clk);
        end
        #1 reset = 1'b1;

        foreach (vecs[k]) begin
            start_instr(vecs[k].op, vecs[k].f3, vecs[k].f7);
            Zero = vecs[k].zero;
            for (int i = 0; i < vecs[k].n; i++) begin
                bit mr;
                mr = !(i >= vecs[k].stall_at && i < vecs[k].stall_at + vecs[k].stall_n);
                step(mr, int'((vecs[k].st >> (4 * i)) & 32'hF), vecs[k].name);
            end
        end

        // Unsupported opcode halts after DECODE.
        start_instr(7'b1110011, 3'b000, 1'b0);
        step(1'b1, 0, "ecall");
        step(1'b1, 1, "ecall");
        step(1'b1, 11, "ecall");
        step(1'b1, 11, "ecall");
        cmp("ecall Halted", 32'(Halted), 1);
        apply_reset(1, 1'b0);

        // Memory never answers in FETCH: TRAP after TO wait cycles, sticky.
        start_instr(7'b0110011, 3'b000, 1'b0);
        repeat (TO) step(1'b0, 0, "timeout");
        step(1'b1, 11, "trapped");
        step(1'b1, 11, "trapped");
        cmp("trap Halted", 32'(Halted), 1);
        apply_reset(2, 1'b0);
        cmp("post-trap Halted", 32'(Halted), 0);

        // Asynchronous reset in the middle of a store.
        start_instr(7'b0100011, 3'b000, 1'b0);
        step(1'b1, 0, "swrst");
        step(1'b1, 1, "swrst");
        step(1'b1, 2, "swrst");
        MemReady = 1'b0;
        #2;
        cmp("swrst MemWrite before", 32'(MemWrite), 1);
        reset = 1'b0;
        #1;
        cmp("swrst MemWrite after", 32'(MemWrite), 0);
        cmp("swrst State after", 32'(State), 0);
        model_reset();
        @(negedge clk);
        cmp("swrst outs", 32'(act_vec), 32'(expect_outs(0, 1'b0)));
        @(posedge clk);
        #1 reset = 1'b1;

        trap_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (need_instr) begin
                int r;
                logic [6:0] o;
                r = $urandom_range(0, 19);
                if (r < 4)       o = 7'b0110011;
                else if (r < 8)  o = 7'b0010011;
                else if (r < 11) o = 7'b0000011;
                else if (r < 14) o = 7'b0100011;
                else if (r < 17) o = 7'b1100011;
                else if (r < 19) o = 7'b1101111;
                else             o = 7'($urandom_range(0, 127));
                start_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            if (cur_phase() == 11) begin
                trap_cycles++;
                if (trap_cycles > 2) begin
                    apply_reset(1, 1'($urandom_range(0, 1)));
                    trap_cycles = 0;
                    continue;
                end
            end
            Zero = 1'($urandom_range(0, 1));
            step($urandom_range(0, 9) < 7, -1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
